// File: rtl/alu_exec_stage.sv
// ALU execute stage: registered single-cycle ops plus an iterative shift-add MULTU, behind valid/ready.
// Optional signed-overflow flag output out_ovf is enabled by defining ALU_EXEC_OVF_EN.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef ALU_EXEC_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, FULL = 2'd1, MUL = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               is_mul;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     step_sum;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;

  always_comb begin
    alu_res = '0;
    case (alu_ct)
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0010: alu_res = op_a + op_b;
      4'b0011: alu_res = op_a ^ op_b;
      4'b0100: alu_res = ~(op_a | op_b);
      4'b0110: alu_res = op_a - op_b;
      default: alu_res = '0;
    endcase
  end

  assign is_mul = (alu_ct == 4'b1000);

  // One shift-add step: {hi,lo} accumulates the product, low bits shift in from the adder LSB.
  assign step_sum = {1'b0, hi_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign step_hi  = step_sum[WIDTH:1];
  assign step_lo  = {step_sum[0], res_q[WIDTH-1:1]};

  assign in_ready = !flush && ((state_q == IDLE) || ((state_q == FULL) && out_ready));
  assign accept   = in_valid && in_ready;

`ifdef ALU_EXEC_OVF_EN
  logic ovf_q, ovf_d;
  logic alu_ovf;

  always_comb begin
    alu_ovf = 1'b0;
    if (alu_ct == 4'b0010)
      alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
    else if (alu_ct == 4'b0110)
      alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (!flush && accept)
      ovf_d = is_mul ? 1'b0 : alu_ovf;
  end

  always_ff @(posedge clk) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign out_ovf = ovf_q;
`endif

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    tag_d    = tag_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, FULL: begin
          if (accept) begin
            tag_d = in_tag;
            if (is_mul) begin
              mcand_d  = op_a;
              mplier_d = op_b;
              res_d    = '0;
              hi_d     = '0;
              zero_d   = 1'b0;
              cnt_d    = '0;
              state_d  = MUL;
            end else begin
              res_d   = alu_res;
              hi_d    = '0;
              zero_d  = (alu_res == '0);
              state_d = FULL;
            end
          end else if (state_q == FULL && out_ready) begin
            state_d = IDLE;
          end
        end
        MUL: begin
          res_d    = step_lo;
          hi_d     = step_hi;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            zero_d  = (step_lo == '0);
            cnt_d   = '0;
            state_d = FULL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      res_q    <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      tag_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      tag_q    <= tag_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign busy       = (state_q == MUL);
  assign out_result = res_q;
  assign out_hi     = hi_q;
  assign out_zero   = zero_q;
  assign out_tag    = tag_q;

endmodule
